// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB (tags 1..ROB_SIZE-1) with CDB writeback, in-order commit and misbranch rollback; ROB_CDB_BYPASS_EN adds same-cycle CDB forwarding to the queries.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_alloc_ena,
  input  logic [4:0]       in_alloc_rd,
  input  logic             in_alloc_is_branch,
  input  logic             in_alloc_pred_taken,
  output logic [TAG_W-1:0] out_alloc_tag,
  output logic             out_full,
  input  logic             in_cdb_ena,
  input  logic [TAG_W-1:0] in_cdb_tag,
  input  logic [31:0]      in_cdb_value,
  input  logic             in_cdb_taken,
  input  logic [31:0]      in_cdb_target,
  input  logic [TAG_W-1:0] in_query_tag1,
  input  logic [TAG_W-1:0] in_query_tag2,
  output logic             out_query_ready1,
  output logic             out_query_ready2,
  output logic [31:0]      out_query_value1,
  output logic [31:0]      out_query_value2,
  output logic [4:0]       out_commit_reg,
  output logic [TAG_W-1:0] out_commit_tag,
  output logic [31:0]      out_commit_value,
  output logic             out_rollback,
  output logic [31:0]      out_rollback_pc
);
  localparam logic [TAG_W-1:0] FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST = TAG_W'(ROB_SIZE - 1);
  logic [ROB_SIZE-1:0] busy, ready, is_br, pred, taken;
  logic [4:0]  rd     [ROB_SIZE];
  logic [31:0] value  [ROB_SIZE];
  logic [31:0] target [ROB_SIZE];
  logic [TAG_W-1:0] head, tail, count;
  logic commit_en, mispredict, alloc_en, cdb_en, byp1, byp2, rdy1, rdy2;
  function automatic logic [TAG_W-1:0] nxt(input logic [TAG_W-1:0] p);
    return p == LAST ? FIRST : p + FIRST;
  endfunction
  assign out_full      = count == LAST;
  assign out_alloc_tag = tail;
  assign commit_en     = ena && !out_rollback && count != '0 && busy[head] && ready[head];
  assign mispredict    = commit_en && is_br[head] && (taken[head] != pred[head]);
  assign alloc_en      = ena && in_alloc_ena && !out_full && !out_rollback;
  assign cdb_en        = ena && in_cdb_ena && !out_rollback && busy[in_cdb_tag];
  assign out_commit_reg   = commit_en ? rd[head] : '0;
  assign out_commit_tag   = commit_en ? head : '0;
  assign out_commit_value = commit_en ? value[head] : '0;
  assign rdy1 = busy[in_query_tag1] && ready[in_query_tag1];
  assign rdy2 = busy[in_query_tag2] && ready[in_query_tag2];
`ifdef ROB_CDB_BYPASS_EN
  assign byp1 = in_cdb_ena && in_cdb_tag == in_query_tag1 && busy[in_query_tag1] && !out_rollback;
  assign byp2 = in_cdb_ena && in_cdb_tag == in_query_tag2 && busy[in_query_tag2] && !out_rollback;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign out_query_ready1 = byp1 || rdy1;
  assign out_query_ready2 = byp2 || rdy2;
  assign out_query_value1 = byp1 ? in_cdb_value : rdy1 ? value[in_query_tag1] : '0;
  assign out_query_value2 = byp2 ? in_cdb_value : rdy2 ? value[in_query_tag2] : '0;
  always_ff @(posedge clk) begin
    if (rst || mispredict) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy[i]   <= 1'b0;
        ready[i]  <= 1'b0;
        is_br[i]  <= 1'b0;
        pred[i]   <= 1'b0;
        taken[i]  <= 1'b0;
        rd[i]     <= '0;
        value[i]  <= '0;
        target[i] <= '0;
      end
      head  <= FIRST;
      tail  <= FIRST;
      count <= '0;
    end else begin
      if (cdb_en) begin
        ready[in_cdb_tag]  <= 1'b1;
        value[in_cdb_tag]  <= in_cdb_value;
        taken[in_cdb_tag]  <= in_cdb_taken;
        target[in_cdb_tag] <= in_cdb_target;
      end
      // head != tail whenever both fire, so these writes never collide
      if (alloc_en) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        rd[tail]    <= in_alloc_rd;
        is_br[tail] <= in_alloc_is_branch;
        pred[tail]  <= in_alloc_pred_taken;
        tail        <= nxt(tail);
      end
      if (commit_en) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= nxt(head);
      end
      count <= count + TAG_W'(alloc_en) - TAG_W'(commit_en);
    end
  end
  always_ff @(posedge clk) begin
    out_rollback <= !rst && mispredict;
    if (rst) out_rollback_pc <= '0;
    else if (mispredict) out_rollback_pc <= target[head];
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
  logic clk = 0, rst, ena, in_alloc_ena, in_alloc_is_branch, in_alloc_pred_taken;
  logic [4:0] in_alloc_rd, out_commit_reg;
  logic [3:0] out_alloc_tag, in_cdb_tag, in_query_tag1, in_query_tag2, out_commit_tag;
  logic out_full, in_cdb_ena, in_cdb_taken, out_query_ready1, out_query_ready2, out_rollback;
  logic [31:0] in_cdb_value, in_cdb_target, out_query_value1, out_query_value2, out_commit_value, out_rollback_pc;
  int checks = 0, errors = 0;
`ifdef ROB_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  reorder_buffer dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_alloc_ena(in_alloc_ena), .in_alloc_rd(in_alloc_rd), .in_alloc_is_branch(in_alloc_is_branch),
    .in_alloc_pred_taken(in_alloc_pred_taken), .out_alloc_tag(out_alloc_tag), .out_full(out_full),
    .in_cdb_ena(in_cdb_ena), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_taken(in_cdb_taken), .in_cdb_target(in_cdb_target),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .out_commit_reg(out_commit_reg), .out_commit_tag(out_commit_tag), .out_commit_value(out_commit_value),
    .out_rollback(out_rollback), .out_rollback_pc(out_rollback_pc)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; ena = 1; in_alloc_ena = 0; in_alloc_rd = 0; in_alloc_is_branch = 0; in_alloc_pred_taken = 0;
    in_cdb_ena = 0; in_cdb_tag = 0; in_cdb_value = 0; in_cdb_taken = 0; in_cdb_target = 0;
    in_query_tag1 = 0; in_query_tag2 = 0;
    tick(); tick();
    rst = 0;
    #1;
  endtask
  task automatic alloc(input logic [4:0] r, input logic br, input logic pt);
    in_alloc_ena = 1; in_alloc_rd = r; in_alloc_is_branch = br; in_alloc_pred_taken = pt;
    tick();
    in_alloc_ena = 0; in_alloc_is_branch = 0; in_alloc_pred_taken = 0;
  endtask
  task automatic set_cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    in_cdb_ena = 1; in_cdb_tag = t; in_cdb_value = v; in_cdb_taken = tk; in_cdb_target = tg;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    in_query_tag1 = 1;
    #1;
    checks++; if (out_alloc_tag !== 4'd1) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 1", out_alloc_tag); end
    checks++; if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", out_full); end
    checks++; if (out_commit_reg !== 5'd0 || out_commit_tag !== 4'd0 || out_commit_value !== 32'd0) begin errors++; $display("FAIL reset_commit got %0d/%0d/%0h exp 0/0/0", out_commit_reg, out_commit_tag, out_commit_value); end
    checks++; if (out_rollback !== 1'b0 || out_rollback_pc !== 32'd0) begin errors++; $display("FAIL reset_rollback got %0b/%0h exp 0/0", out_rollback, out_rollback_pc); end
    checks++; if (out_query_ready1 !== 1'b0 || out_query_value1 !== 32'd0) begin errors++; $display("FAIL reset_query got %0b/%0h exp 0/0", out_query_ready1, out_query_value1); end
  endtask
  task automatic test_basic();
    do_reset();
    alloc(5'd5, 0, 0);
    checks++; if (out_alloc_tag !== 4'd2) begin errors++; $display("FAIL basic_tail got %0d exp 2", out_alloc_tag); end
    set_cdb(4'd1, 32'h1234, 0, 0);
    tick();
    in_cdb_ena = 0; in_query_tag1 = 1;
    #1;
    checks++; if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'h1234) begin errors++; $display("FAIL basic_query got %0b/%0h exp 1/1234", out_query_ready1, out_query_value1); end
    checks++; if (out_commit_reg !== 5'd5 || out_commit_tag !== 4'd1 || out_commit_value !== 32'h1234) begin errors++; $display("FAIL basic_commit got %0d/%0d/%0h exp 5/1/1234", out_commit_reg, out_commit_tag, out_commit_value); end
    tick();
    checks++; if (out_commit_tag !== 4'd0 || out_query_ready1 !== 1'b0) begin errors++; $display("FAIL basic_after got tag %0d rdy %0b exp 0/0", out_commit_tag, out_query_ready1); end
  endtask
  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 15; i++) alloc(5'(i), 0, 0);
    checks++; if (out_full !== 1'b1 || out_alloc_tag !== 4'd1) begin errors++; $display("FAIL full_15 got full %0b tag %0d exp 1/1", out_full, out_alloc_tag); end
    alloc(5'd7, 0, 0);
    checks++; if (out_full !== 1'b1 || out_alloc_tag !== 4'd1) begin errors++; $display("FAIL full_drop got full %0b tag %0d exp 1/1", out_full, out_alloc_tag); end
    set_cdb(4'd1, 32'hAA, 0, 0);
    tick();
    in_cdb_ena = 0; in_alloc_ena = 1; in_alloc_rd = 5'd9;
    #1;
    checks++; if (out_commit_reg !== 5'd1 || out_commit_value !== 32'hAA || out_full !== 1'b1) begin errors++; $display("FAIL full_commit got %0d/%0h full %0b exp 1/aa/1", out_commit_reg, out_commit_value, out_full); end
    tick();
    in_alloc_ena = 0;
    #1;
    checks++; if (out_full !== 1'b0 || out_alloc_tag !== 4'd1) begin errors++; $display("FAIL full_after got full %0b tag %0d exp 0/1", out_full, out_alloc_tag); end
    set_cdb(4'd2, 32'hBB, 0, 0);
    tick();
    in_cdb_ena = 0; in_alloc_ena = 1; in_alloc_rd = 5'd3;
    #1;
    checks++; if (out_commit_reg !== 5'd2 || out_commit_tag !== 4'd2) begin errors++; $display("FAIL full_commit2 got %0d/%0d exp 2/2", out_commit_reg, out_commit_tag); end
    tick();
    checks++; if (out_full !== 1'b0 || out_alloc_tag !== 4'd2) begin errors++; $display("FAIL alloc_commit got full %0b tag %0d exp 0/2", out_full, out_alloc_tag); end
    tick();
    in_alloc_ena = 0;
    #1;
    checks++; if (out_full !== 1'b1 || out_alloc_tag !== 4'd3) begin errors++; $display("FAIL refill got full %0b tag %0d exp 1/3", out_full, out_alloc_tag); end
  endtask
  task automatic test_in_order();
    do_reset();
    alloc(5'd10, 0, 0); alloc(5'd11, 0, 0); alloc(5'd12, 0, 0);
    set_cdb(4'd3, 32'h33, 0, 0);
    checks++; if (out_commit_tag !== 4'd0) begin errors++; $display("FAIL order_c3 got %0d exp 0", out_commit_tag); end
    tick();
    set_cdb(4'd2, 32'h22, 0, 0);
    checks++; if (out_commit_tag !== 4'd0) begin errors++; $display("FAIL order_c2 got %0d exp 0", out_commit_tag); end
    tick();
    set_cdb(4'd1, 32'h11, 0, 0);
    checks++; if (out_commit_tag !== 4'd0) begin errors++; $display("FAIL order_cdb_head got %0d exp 0", out_commit_tag); end
    tick();
    in_cdb_ena = 0;
    #1;
    checks++; if (out_commit_tag !== 4'd1 || out_commit_reg !== 5'd10 || out_commit_value !== 32'h11) begin errors++; $display("FAIL order_1 got %0d/%0d/%0h exp 1/10/11", out_commit_tag, out_commit_reg, out_commit_value); end
    tick();
    checks++; if (out_commit_tag !== 4'd2 || out_commit_reg !== 5'd11 || out_commit_value !== 32'h22) begin errors++; $display("FAIL order_2 got %0d/%0d/%0h exp 2/11/22", out_commit_tag, out_commit_reg, out_commit_value); end
    tick();
    checks++; if (out_commit_tag !== 4'd3 || out_commit_reg !== 5'd12 || out_commit_value !== 32'h33) begin errors++; $display("FAIL order_3 got %0d/%0d/%0h exp 3/12/33", out_commit_tag, out_commit_reg, out_commit_value); end
    tick();
    checks++; if (out_commit_tag !== 4'd0 || out_alloc_tag !== 4'd4) begin errors++; $display("FAIL order_empty got tag %0d alloc %0d exp 0/4", out_commit_tag, out_alloc_tag); end
  endtask
  task automatic test_rollback();
    do_reset();
    alloc(5'd1, 0, 0); alloc(5'd0, 1, 0); alloc(5'd3, 0, 0);
    set_cdb(4'd1, 32'h1, 0, 0);
    tick();
    set_cdb(4'd3, 32'h3, 0, 0);
    checks++; if (out_commit_tag !== 4'd1) begin errors++; $display("FAIL rb_commit1 got %0d exp 1", out_commit_tag); end
    tick();
    set_cdb(4'd2, 32'h0, 1, 32'h80);
    tick();
    in_cdb_ena = 0;
    #1;
    checks++; if (out_commit_tag !== 4'd2 || out_commit_reg !== 5'd0 || out_rollback !== 1'b0) begin errors++; $display("FAIL rb_branch got tag %0d reg %0d rb %0b exp 2/0/0", out_commit_tag, out_commit_reg, out_rollback); end
    tick();
    in_alloc_ena = 1; in_alloc_rd = 5'd4; in_query_tag1 = 3;
    #1;
    checks++; if (out_rollback !== 1'b1 || out_rollback_pc !== 32'h80) begin errors++; $display("FAIL rb_pulse got %0b/%0h exp 1/80", out_rollback, out_rollback_pc); end
    checks++; if (out_commit_tag !== 4'd0 || out_alloc_tag !== 4'd1 || out_full !== 1'b0 || out_query_ready1 !== 1'b0) begin errors++; $display("FAIL rb_state got c %0d a %0d f %0b q %0b exp 0/1/0/0", out_commit_tag, out_alloc_tag, out_full, out_query_ready1); end
    tick();
    checks++; if (out_rollback !== 1'b0 || out_alloc_tag !== 4'd1) begin errors++; $display("FAIL rb_end got rb %0b tag %0d exp 0/1", out_rollback, out_alloc_tag); end
    tick();
    in_alloc_ena = 0;
    #1;
    checks++; if (out_alloc_tag !== 4'd2 || out_commit_tag !== 4'd0) begin errors++; $display("FAIL rb_realloc got tag %0d commit %0d exp 2/0", out_alloc_tag, out_commit_tag); end
  endtask
  task automatic test_bypass();
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(5'(i), 0, 0);
    in_query_tag1 = 4; in_query_tag2 = 0;
    set_cdb(4'd4, 32'h44, 0, 0);
    checks++; if (out_query_ready1 !== BYP || out_query_value1 !== (BYP ? 32'h44 : 32'h0)) begin errors++; $display("FAIL bypass_same got %0b/%0h exp %0b", out_query_ready1, out_query_value1, BYP); end
    tick();
    in_cdb_ena = 0;
    #1;
    checks++; if (out_query_ready1 !== 1'b1 || out_query_value1 !== 32'h44) begin errors++; $display("FAIL bypass_next got %0b/%0h exp 1/44", out_query_ready1, out_query_value1); end
    checks++; if (out_query_ready2 !== 1'b0 || out_query_value2 !== 32'h0) begin errors++; $display("FAIL query_tag0 got %0b/%0h exp 0/0", out_query_ready2, out_query_value2); end
  endtask
  task automatic test_enable();
    do_reset();
    ena = 0;
    alloc(5'd6, 0, 0);
    checks++; if (out_alloc_tag !== 4'd1) begin errors++; $display("FAIL ena_hold got %0d exp 1", out_alloc_tag); end
    ena = 1;
    alloc(5'd6, 0, 0);
    set_cdb(4'd1, 32'h66, 0, 0);
    tick();
    in_cdb_ena = 0; ena = 0;
    #1;
    checks++; if (out_commit_tag !== 4'd0) begin errors++; $display("FAIL ena_commit got %0d exp 0", out_commit_tag); end
    ena = 1;
    #1;
    checks++; if (out_commit_tag !== 4'd1 || out_commit_reg !== 5'd6) begin errors++; $display("FAIL ena_resume got %0d/%0d exp 1/6", out_commit_tag, out_commit_reg); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_in_order();
    test_rollback();
    test_bypass();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
